// File: rtl/fifo_pkg.sv
// Shared definitions for the multi-channel FIFO bank.
// Holds the tag-width helper and the bit positions of the sticky error vector.
// No logic of its own; imported by the channel and the top.
package fifo_pkg;

    // Bit positions inside the sticky err vector
    typedef enum logic [1:0] {
        ERR_OVF = 2'd0,   // write while full (or to a nonexistent channel)
        ERR_UFL = 2'd1,   // read while empty
        ERR_SEL = 2'd2    // read on a non-selected channel, or multi-hot read
    } err_e;

    // Channel index width; a single channel still gets a 1-bit tag
    function automatic int tag_width(input int flux);
        return (flux <= 1) ? 1 : $clog2(flux);
    endfunction

endpackage

// File: rtl/flux_fifo_channel.sv
// One circular buffer of DEPTH words with first-word-fall-through head.
// Latency: push/pop take effect at the rising edge; head/empty/full follow from registers.
// Backpressure: push ignored while full, pop ignored while empty; same-cycle push+pop keeps count.
module flux_fifo_channel #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset; pointers decide what is valid
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; count moves only when exactly one side is active
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/flux_fifo.sv
// FLUX-channel FIFO bank: tagged writes in, per-channel empty flags and shared FWFT dout out.
// Latency: one cycle from write to empty/dout, one cycle from pop to the next head.
// Backpressure: combinational full for wr_tag; illegal writes/reads are dropped and flagged in sticky err.
module flux_fifo
    import fifo_pkg::*;
#(
    parameter int FLUX       = 2,
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = tag_width(FLUX)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [TAG_WIDTH-1:0]  wr_tag,
    output logic                  full,
    output logic [FLUX-1:0]       empty,
    input  logic [FLUX-1:0]       read,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [2:0]            err
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [FLUX-1:0]                 push;
    logic [FLUX-1:0]                 pop;
    logic [FLUX-1:0]                 ch_empty;
    logic [FLUX-1:0]                 ch_full;
    logic [FLUX-1:0][DATA_WIDTH-1:0] ch_head;
    logic [FLUX-1:0][CW-1:0]         ch_count;

    logic                 tag_ok;
    logic [TAG_WIDTH-1:0] sel;
    logic [FLUX-1:0]      sel_hot;
    logic                 any_ne;
    logic                 multi;

    for (genvar g = 0; g < FLUX; g++) begin : g_ch
        flux_fifo_channel #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (din),
            .head  (ch_head[g]),
            .count (ch_count[g]),
            .empty (ch_empty[g]),
            .full  (ch_full[g])
        );
    end

    assign empty = ch_empty;

    // Tag decode: full reflects the addressed channel only; out-of-range tags address nothing
    always_comb begin
        tag_ok = (32'(wr_tag) < FLUX);
        full   = 1'b0;
        push   = '0;
        for (int i = 0; i < FLUX; i++) begin
            if (32'(wr_tag) == i) begin
                full    = (ch_count[i] == CW'(DEPTH));
                push[i] = write && !ch_full[i];
            end
        end
    end

    // Priority encoder: lowest non-empty channel wins, matching consumer arbitration
    always_comb begin
        sel     = '0;
        sel_hot = '0;
        any_ne  = 1'b0;
        for (int i = FLUX - 1; i >= 0; i--) begin
            if (!ch_empty[i]) begin
                sel        = TAG_WIDTH'(i);
                sel_hot    = '0;
                sel_hot[i] = 1'b1;
                any_ne     = 1'b1;
            end
        end
    end

    // Shared FWFT output; zero when nothing is buffered
    always_comb begin
        dout = '0;
        for (int i = 0; i < FLUX; i++) begin
            if (any_ne && (32'(sel) == i)) begin
                dout = ch_head[i];
            end
        end
    end

    // A multi-hot read is rejected as a whole; otherwise only a pop of the selected channel goes through
    always_comb begin
        multi = |(read & (read - FLUX'(1)));
        pop   = multi ? '0 : (read & ~ch_empty & sel_hot);
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= '0;
        end else begin
            if (write && (!tag_ok || full)) begin
                err[ERR_OVF] <= 1'b1;
            end
            if (|(read & ch_empty)) begin
                err[ERR_UFL] <= 1'b1;
            end
            if (multi || |(read & ~ch_empty & ~sel_hot)) begin
                err[ERR_SEL] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flux_fifo.sv
// Scoreboard bench for flux_fifo (FLUX=2, DEPTH=8, 32-bit data).
// Inputs driven at the falling edge, outputs compared at the falling edge before new inputs.
// Per-channel expected-word queues are filled on accepted writes and drained on accepted pops.
module tb_flux_fifo;

    localparam int FLUX  = 2;
    localparam int DEPTH = 8;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          write;
    logic [DW-1:0] din;
    logic [0:0]    wr_tag;
    logic          full;
    logic [1:0]    empty;
    logic [1:0]    read;
    logic [DW-1:0] dout;
    logic [2:0]    err;

    int n_checks = 0;
    int n_err    = 0;

    logic [DW-1:0] mq [FLUX][$];
    logic [2:0]    m_err;

    flux_fifo #(
        .FLUX       (FLUX),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .write  (write),
        .din    (din),
        .wr_tag (wr_tag),
        .full   (full),
        .empty  (empty),
        .read   (read),
        .dout   (dout),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle of stimulus, entered and left at a falling edge
    task automatic do_cycle(input bit wr, input int tag, input logic [DW-1:0] d, input logic [1:0] rd);
        logic [1:0]    m_empty;
        int            s;
        bit            any;
        bit            push_ok;
        bit            pop_ok;
        bit            multi;
        logic [1:0]    hot;
        logic [DW-1:0] exp_head;
        logic [DW-1:0] popped;

        any = 0;
        s   = 0;
        for (int i = FLUX - 1; i >= 0; i--) begin
            m_empty[i] = (mq[i].size() == 0);
            if (mq[i].size() != 0) begin
                s   = i;
                any = 1;
            end
        end
        hot      = any ? (2'b01 << s) : 2'b00;
        exp_head = any ? mq[s][0] : '0;

        write  = wr;
        wr_tag = tag[0];
        din    = d;
        read   = rd;
        #1;

        chk("empty", empty, m_empty);
        chk("dout", dout, exp_head);
        chk("full", full, mq[tag].size() == DEPTH);

        multi   = (rd == 2'b11);
        pop_ok  = !multi && ((rd & ~m_empty & hot) != 0);
        push_ok = wr && (mq[tag].size() < DEPTH);

        if (wr && !push_ok) m_err[0] = 1'b1;
        if ((rd & m_empty) != 0) m_err[1] = 1'b1;
        if (multi || ((rd & ~m_empty & ~hot) != 0)) m_err[2] = 1'b1;

        if (pop_ok) begin
            popped = mq[s].pop_front();
            chk("pop_data", dout, popped);
        end

        @(posedge clk);
        if (push_ok) mq[tag].push_back(d);
        @(negedge clk);
        write = 1'b0;
        read  = 2'b00;
        chk("err", err, m_err);
    endtask

    task automatic idle(input int tag);
        do_cycle(0, tag, '0, 2'b00);
    endtask

    // One-cycle reset; a write is held active during it to show reset wins
    task automatic do_reset();
        rst_n  = 1'b0;
        write  = 1'b1;
        wr_tag = 1'b1;
        din    = 32'hDEAD_BEEF;
        read   = 2'b01;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        write = 1'b0;
        read  = 2'b00;
        for (int i = 0; i < FLUX; i++) mq[i].delete();
        m_err = '0;
        #1;
        chk("rst_empty", empty, 2'b11);
        chk("rst_err", err, 3'b000);
        chk("rst_dout", dout, '0);
    endtask

    initial begin
        rst_n  = 1'b0;
        write  = 1'b0;
        din    = '0;
        wr_tag = '0;
        read   = '0;
        m_err  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state and a single write to ch1
        chk("init_empty", empty, 2'b11);
        chk("init_dout", dout, '0);
        chk("init_err", err, 3'b000);
        idle(0);
        idle(1);
        do_cycle(1, 1, 32'hA5, 2'b00);
        chk("a5_empty", empty, 2'b01);
        chk("a5_dout", dout, 32'hA5);
        do_cycle(0, 0, '0, 2'b10);

        // Offset ch0 pointers so the fill/drain crosses the wrap
        for (int i = 0; i < 3; i++) do_cycle(1, 0, 32'h100 + i, 2'b00);
        for (int i = 0; i < 3; i++) do_cycle(0, 0, '0, 2'b01);
        for (int i = 0; i < 8; i++) do_cycle(1, 0, i, 2'b00);
        chk("fill_full0", full, 1'b1);
        idle(1);
        do_cycle(1, 0, 32'h99, 2'b00);
        chk("ovf_err", err[0], 1'b1);
        for (int i = 0; i < 8; i++) do_cycle(0, 0, '0, 2'b01);
        chk("drain_empty", empty, 2'b11);

        // Channel priority and selection errors
        do_reset();
        do_cycle(1, 0, 32'h10, 2'b00);
        do_cycle(1, 1, 32'h20, 2'b00);
        chk("prio_dout", dout, 32'h10);
        do_cycle(0, 0, '0, 2'b01);
        chk("next_ch_dout", dout, 32'h20);
        do_cycle(1, 0, 32'h11, 2'b00);
        do_cycle(0, 0, '0, 2'b10);
        chk("sel_err", err, 3'b100);
        do_cycle(0, 0, '0, 2'b11);
        do_cycle(0, 0, '0, 2'b01);
        do_cycle(0, 0, '0, 2'b10);
        do_cycle(0, 0, '0, 2'b01);
        chk("ufl_err", err[1], 1'b1);

        // Sustained streaming: 4 words buffered, one in and one out per cycle
        do_reset();
        for (int i = 0; i < 4; i++) do_cycle(1, 0, 32'hC000 + i, 2'b00);
        for (int i = 4; i < 24; i++) do_cycle(1, 0, 32'hC000 + i, 2'b01);
        chk("stream_cnt", mq[0].size(), 4);
        for (int i = 0; i < 4; i++) do_cycle(0, 0, '0, 2'b01);
        chk("stream_err", err, 3'b000);

        // Full channel with same-cycle write and pop: pop wins, write dropped
        do_reset();
        for (int i = 0; i < 8; i++) do_cycle(1, 0, $urandom, 2'b00);
        do_cycle(1, 0, 32'h77, 2'b01);
        chk("fullrw_err", err, 3'b001);
        chk("fullrw_full", full, 1'b0);
        for (int i = 0; i < 7; i++) do_cycle(0, 0, '0, 2'b01);
        chk("fullrw_drain", empty, 2'b11);

        // Reset with data in ch1, then reuse
        for (int i = 0; i < 3; i++) do_cycle(1, 1, 32'h50 + i, 2'b00);
        chk("pre_rst_empty", empty, 2'b01);
        do_reset();
        idle(1);
        do_cycle(1, 1, 32'h33, 2'b00);
        chk("post_rst_dout", dout, 32'h33);
        do_cycle(0, 1, '0, 2'b10);
        chk("post_rst_empty", empty, 2'b11);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
